pid_cfg_sequencer: RTL

- Queues host gain/limit writes for the D-axis and Q-axis PID controllers and applies them only between FOC loop iterations.
- PID coefficients therefore never change mid-iteration.
- Sits beside the FOC top-level sequencer. It requests a hold, waits for a grant (loop idle), drains the queue onto the pid_d/pid_q config ports, then releases the hold.

---
 rtl/pid_cfg_sequencer_pkg.sv | 39 +++
 rtl/pid_cfg_sequencer_if.sv | 44 ++++
 rtl/pid_cfg_sequencer_fifo.sv | 57 +++++
 rtl/pid_cfg_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pid_cfg_sequencer_pkg.sv
// Shared types for the PID config sequencer: target select, FSM states
// and the queued config entry. D_WIDTH of the sequencer must equal CFG_DW.
package foc_cfg_pkg;

  localparam int CFG_DW = 16;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_D    = 2'b01,
    SEL_Q    = 2'b10,
    SEL_BOTH = 2'b11
  } cfg_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } cfg_state_t;

  typedef struct packed {
    cfg_sel_t            sel;
    logic [CFG_DW-1:0]   addr;
    logic [CFG_DW-1:0]   data;
  } cfg_entry_t;

  function automatic logic sel_hits_d(cfg_sel_t s);
    logic [1:0] b;
    b = s;
    return b[0];
  endfunction

  function automatic logic sel_hits_q(cfg_sel_t s);
    logic [1:0] b;
    b = s;
    return b[1];
  endfunction

endpackage

// File: rtl/pid_cfg_sequencer_if.sv
// Host/loop/PID bundle of the config sequencer.
// master: host + FOC side (drives requests); slave: the sequencer.
interface pid_cfg_sequencer_if #(
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               host_valid;
  logic               host_ready;
  logic [1:0]         host_sel;
  logic [D_WIDTH-1:0] host_addr;
  logic [D_WIDTH-1:0] host_data;
  logic               loop_idle;
  logic               cfg_hold;
  logic               pid_d_wen;
  logic [D_WIDTH-1:0] pid_d_addr;
  logic [D_WIDTH-1:0] pid_d_data;
  logic               pid_q_wen;
  logic [D_WIDTH-1:0] pid_q_addr;
  logic [D_WIDTH-1:0] pid_q_data;
  logic [CW-1:0]      fifo_count;
  logic               sel_err;

  modport master (
    output host_valid, host_sel, host_addr, host_data,
    output loop_idle,
    input  host_ready, cfg_hold,
    input  pid_d_wen, pid_d_addr, pid_d_data,
    input  pid_q_wen, pid_q_addr, pid_q_data,
    input  fifo_count, sel_err
  );

  modport slave (
    input  host_valid, host_sel, host_addr, host_data,
    input  loop_idle,
    output host_ready, cfg_hold,
    output pid_d_wen, pid_d_addr, pid_d_data,
    output pid_q_wen, pid_q_addr, pid_q_data,
    output fifo_count, sel_err
  );

endinterface

// File: rtl/pid_cfg_sequencer_fifo.sv
// cfg_fifo: synchronous FIFO of cfg_entry_t, async active-high reset.
// Ports: i_push/i_wr, i_pop, o_head (show-ahead), o_full, o_empty, o_count.
module cfg_fifo
  import foc_cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  cfg_entry_t             i_wr,
  input  logic                   i_pop,
  output cfg_entry_t             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  cfg_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr;
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pid_cfg_sequencer.sv
// Queues host PID gain/limit writes and applies them between FOC iterations.
// Ports: clk, reset (async, active-high), bus (slave: host/loop/PID signals).
module pid_cfg_sequencer
  import foc_cfg_pkg::*;
#(
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pid_cfg_sequencer_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cfg_state_t          r_state;
  cfg_state_t          w_state_n;
  logic                r_hold;
  logic                w_hold_n;
  logic [CW-1:0]       r_drain;
  logic [CW-1:0]       w_drain_n;
  logic                r_d_wen;
  logic                w_d_wen_n;
  logic [D_WIDTH-1:0]  r_d_addr;
  logic [D_WIDTH-1:0]  w_d_addr_n;
  logic [D_WIDTH-1:0]  r_d_data;
  logic [D_WIDTH-1:0]  w_d_data_n;
  logic                r_q_wen;
  logic                w_q_wen_n;
  logic [D_WIDTH-1:0]  r_q_addr;
  logic [D_WIDTH-1:0]  w_q_addr_n;
  logic [D_WIDTH-1:0]  r_q_data;
  logic [D_WIDTH-1:0]  w_q_data_n;
  logic                r_sel_err;

  logic                w_hs;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  cfg_entry_t          w_wr;
  cfg_entry_t          w_head;

  assign bus.host_ready = !reset && !w_full;

  assign w_hs   = bus.host_valid && bus.host_ready;
  assign w_push = w_hs && (bus.host_sel != 2'b00);

  assign w_wr.sel  = cfg_sel_t'(bus.host_sel);
  assign w_wr.addr = bus.host_addr;
  assign w_wr.data = bus.host_data;

  cfg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wr    (w_wr),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_n  = r_state;
    w_hold_n   = r_hold;
    w_drain_n  = r_drain;
    w_pop      = 1'b0;
    w_d_wen_n  = 1'b0;
    w_d_addr_n = r_d_addr;
    w_d_data_n = r_d_data;
    w_q_wen_n  = 1'b0;
    w_q_addr_n = r_q_addr;
    w_q_data_n = r_q_data;
    unique case (r_state)
      IDLE: begin
        if (!w_empty && bus.loop_idle) begin
          w_state_n = REQ;
          w_hold_n  = 1'b1;
        end
      end
      REQ: begin
        // Hold has been visible a full cycle; idle now means granted.
        // Only entries queued so far belong to this drain.
        if (bus.loop_idle) begin
          w_state_n = DRAIN;
          w_drain_n = w_count;
        end
      end
      DRAIN: begin
        w_pop = 1'b1;
        if (sel_hits_d(w_head.sel)) begin
          w_d_wen_n  = 1'b1;
          w_d_addr_n = w_head.addr;
          w_d_data_n = w_head.data;
        end
        if (sel_hits_q(w_head.sel)) begin
          w_q_wen_n  = 1'b1;
          w_q_addr_n = w_head.addr;
          w_q_data_n = w_head.data;
        end
        w_drain_n = r_drain - 1'b1;
        if (r_drain == CW'(1)) w_state_n = DONE;
      end
      DONE: begin
        w_hold_n  = 1'b0;
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= 1'b0;
      r_drain   <= '0;
      r_d_wen   <= 1'b0;
      r_d_addr  <= '0;
      r_d_data  <= '0;
      r_q_wen   <= 1'b0;
      r_q_addr  <= '0;
      r_q_data  <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_hold    <= w_hold_n;
      r_drain   <= w_drain_n;
      r_d_wen   <= w_d_wen_n;
      r_d_addr  <= w_d_addr_n;
      r_d_data  <= w_d_data_n;
      r_q_wen   <= w_q_wen_n;
      r_q_addr  <= w_q_addr_n;
      r_q_data  <= w_q_data_n;
      r_sel_err <= w_hs && (bus.host_sel == 2'b00);
    end
  end

  assign bus.cfg_hold   = r_hold;
  assign bus.pid_d_wen  = r_d_wen;
  assign bus.pid_d_addr = r_d_addr;
  assign bus.pid_d_data = r_d_data;
  assign bus.pid_q_wen  = r_q_wen;
  assign bus.pid_q_addr = r_q_addr;
  assign bus.pid_q_data = r_q_data;
  assign bus.fifo_count = w_count;
  assign bus.sel_err    = r_sel_err;

  // The loop must stay idle while coefficients are being rewritten.
  a_idle_in_drain : assert property (
    @(posedge clk) disable iff (reset)
    (r_state == DRAIN) |-> bus.loop_idle
  );

endmodule
